idex_pipe_reg: RTL and testbench
================================

// Module: idex_pipe_reg
// PURPOSE
//  ID/EX pipeline register; consumer of the hazard unit's IDEX_Clear.
//  Latches decoded ID-stage payload each cycle and inserts a true bubble
//  (all control zero, valid=0) on load-use clear or branch flush.
//  Holds contents on downstream stall and counts inserted bubbles for perf.
// PARAMETERS
//  DW      32  datapath width (pc, pc_plus4, inst, immExt, busA, busB)
//  CTRL_W  24  packed ID control bundle width (RegDST..jalr, lb/lbu/sb)
//  CNT_W   16  bubble/flush counter width
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       async active-high reset
//  ex_stall     in   1       EX cannot accept; hold ID/EX contents
//  idex_clear   in   1       load-use bubble request (from hazard unit)
//  flush        in   1       branch/jump resolved taken; kill ID instruction
//  id_valid     in   1       ID stage holds a real instruction
//  id_pc        in   DW      PC of ID instruction
//  id_pc_plus4  in   DW      PC+4
//  id_inst      in   DW      raw instruction word
//  id_imm       in   DW      extended immediate
//  id_busA      in   DW      rs read data
//  id_busB      in   DW      rt read data
//  id_rs,id_rt,id_rd in 5    register specifiers
//  id_shamt     in   5       shift amount
//  id_aluctr    in   5       ALU control
//  id_ctrl      in   CTRL_W  packed control bits
//  ex_valid     out  1       EX holds a real instruction
//  ex_pc..ex_ctrl out (same widths)  registered copies of id_* payload
//  bubble_cnt   out  CNT_W   count of bubbles inserted by idex_clear
//  flush_cnt    out  CNT_W   count of cycles killed by flush
// BEHAVIOUR
//  - rst asserted (any time, async): every output -> 0, counters -> 0.
//  - Per rising edge, priority: flush > ex_stall > idex_clear > load.
//  - flush: ex_valid<=0, all ex_* payload and ex_ctrl/ex_aluctr <=0;
//    flush_cnt+1 if id_valid=1. Flush overrides stall (kill wins).
//  - ex_stall (no flush): all ex_* and ex_valid hold; counters hold;
//    pending idex_clear ignored this cycle (hazard unit re-asserts).
//  - idex_clear (no flush/stall): bubble: ex_valid<=0, ex_ctrl<=0,
//    ex_aluctr<=0, ex_shamt<=0, data/specifier outputs <=0;
//    bubble_cnt+1. No control bit survives (incl. Branch).
//  - load: ex_*<=id_*, ex_valid<=id_valid; 1-cycle latency.
//  - id_valid=0 on load: payload copied, but ex_ctrl forced 0 so an
//    invalid slot never writes regs/memory.
//  - Counters saturate at 2^CNT_W-1; no wrap.
//  - Reg-specifier outputs are zero in bubbles so forwarding never
//    matches a killed slot ($0 writes are ignored downstream).
//  - No combinational path from any input to any output.
// TESTING
//  1 Reset mid-load: load pc=0x40, assert rst mid-cycle -> all outputs 0
//    immediately, counters 0; release, next edge loads normally.
//  2 Plain load: id_valid=1,id_pc=0x100,id_ctrl=0x5A5 -> next edge
//    ex_pc=0x100, ex_ctrl=0x5A5, ex_valid=1.
//  3 Load-use: idex_clear=1 one cycle with id_ctrl=all-ones ->
//    ex_valid=0, ex_ctrl=0, ex_rt=0, bubble_cnt=1; next cycle reloads.
//  4 Stall hold: load pc=0x200, then ex_stall=1 for 3 cycles with new
//    id_pc=0x204 and idex_clear=1 -> ex_pc stays 0x200, bubble_cnt unchanged.
//  5 Flush vs stall: ex_stall=1,flush=1,id_valid=1 -> ex_valid=0,
//    payload 0, flush_cnt+1.
//  6 Saturation (CNT_W=4): 20 consecutive clears -> bubble_cnt=15.

Source files
------------

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: latches the decoded ID payload and inserts true bubbles
// on load-use clear or branch flush. It also keeps saturating counters for inserted bubbles and flushed slots.
module idex_pipe_reg #(
  parameter int DW     = 32,
  parameter int CTRL_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_stall,
  input  logic              idex_clear,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DW-1:0]     id_pc,
  input  logic [DW-1:0]     id_pc_plus4,
  input  logic [DW-1:0]     id_inst,
  input  logic [DW-1:0]     id_imm,
  input  logic [DW-1:0]     id_busA,
  input  logic [DW-1:0]     id_busB,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [4:0]        id_aluctr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [DW-1:0]     ex_pc,
  output logic [DW-1:0]     ex_pc_plus4,
  output logic [DW-1:0]     ex_inst,
  output logic [DW-1:0]     ex_imm,
  output logic [DW-1:0]     ex_busA,
  output logic [DW-1:0]     ex_busB,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [4:0]        ex_aluctr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic [DW-1:0]     pc;
    logic [DW-1:0]     pc_plus4;
    logic [DW-1:0]     inst;
    logic [DW-1:0]     imm;
    logic [DW-1:0]     busA;
    logic [DW-1:0]     busB;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [4:0]        aluctr;
    logic [CTRL_W-1:0] ctrl;
  } pay_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pay_t             pay_q, pay_d, id_pay;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d, fcnt_q, fcnt_d;

  always_comb begin
    id_pay = '{pc: id_pc, pc_plus4: id_pc_plus4, inst: id_inst, imm: id_imm,
               busA: id_busA, busB: id_busB, rs: id_rs, rt: id_rt, rd: id_rd,
               shamt: id_shamt, aluctr: id_aluctr, ctrl: id_ctrl};
  end

  // Priority: flush > stall > clear > load. Bubbles zero everything, so that
  // forwarding cannot match a killed slot's specifiers.
  always_comb begin
    pay_d  = pay_q;
    vld_d  = vld_q;
    bcnt_d = bcnt_q;
    fcnt_d = fcnt_q;
    if (flush) begin
      pay_d = '0;
      vld_d = 1'b0;
      if (id_valid && fcnt_q != CNT_MAX) fcnt_d = fcnt_q + 1'b1;
    end else if (ex_stall) begin
      pay_d = pay_q;
    end else if (idex_clear) begin
      pay_d = '0;
      vld_d = 1'b0;
      if (bcnt_q != CNT_MAX) bcnt_d = bcnt_q + 1'b1;
    end else begin
      pay_d = id_pay;
      vld_d = id_valid;
      if (!id_valid) pay_d.ctrl = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pay_q  <= '0;
      vld_q  <= 1'b0;
      bcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      pay_q  <= pay_d;
      vld_q  <= vld_d;
      bcnt_q <= bcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign ex_valid    = vld_q;
  assign ex_pc       = pay_q.pc;
  assign ex_pc_plus4 = pay_q.pc_plus4;
  assign ex_inst     = pay_q.inst;
  assign ex_imm      = pay_q.imm;
  assign ex_busA     = pay_q.busA;
  assign ex_busB     = pay_q.busB;
  assign ex_rs       = pay_q.rs;
  assign ex_rt       = pay_q.rt;
  assign ex_rd       = pay_q.rd;
  assign ex_shamt    = pay_q.shamt;
  assign ex_aluctr   = pay_q.aluctr;
  assign ex_ctrl     = pay_q.ctrl;
  assign bubble_cnt  = bcnt_q;
  assign flush_cnt   = fcnt_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg: a vector table covers per-edge priority,
// and hand-written sequences cover async reset and counter saturation.
module tb_idex_pipe_reg;
  localparam int DW = 32, CW = 24;

  logic clk = 1'b0, rst = 1'b1;
  logic ex_stall = 0, idex_clear = 0, flush = 0, id_valid = 0;
  logic [DW-1:0] id_pc = '0, id_pc_plus4, id_inst, id_imm, id_busA, id_busB;
  logic [4:0]    id_rs, id_rt = '0, id_rd, id_shamt, id_aluctr;
  logic [CW-1:0] id_ctrl = '0;

  logic          ex_valid;
  logic [DW-1:0] ex_pc, ex_pc_plus4, ex_inst, ex_imm, ex_busA, ex_busB;
  logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt, ex_aluctr;
  logic [CW-1:0] ex_ctrl;
  logic [15:0]   bubble_cnt, flush_cnt;

  logic          s_valid;
  logic [DW-1:0] s_pc, s_pc_plus4, s_inst, s_imm, s_busA, s_busB;
  logic [4:0]    s_rs, s_rt, s_rd, s_shamt, s_aluctr;
  logic [CW-1:0] s_ctrl;
  logic [3:0]    s_bcnt, s_fcnt;

  // Secondary payload fields are derived from pc/rt so that one table column drives all of them.
  always_comb begin
    id_pc_plus4 = id_pc + 32'd4;
    id_inst     = {id_pc[15:0], 16'hBEEF};
    id_imm      = id_pc << 1;
    id_busA     = ~id_pc;
    id_busB     = id_pc + 32'd7;
    id_rs       = id_pc[6:2];
    id_rd       = id_rt + 5'd1;
    id_shamt    = 5'd3;
    id_aluctr   = 5'h11;
  end

  always #5 clk = ~clk;

  idex_pipe_reg dut (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .idex_clear(idex_clear), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst),
    .id_imm(id_imm), .id_busA(id_busA), .id_busB(id_busB), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_aluctr(id_aluctr), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_inst(ex_inst),
    .ex_imm(ex_imm), .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_aluctr(ex_aluctr), .ex_ctrl(ex_ctrl),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));

  idex_pipe_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .idex_clear(idex_clear), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst),
    .id_imm(id_imm), .id_busA(id_busA), .id_busB(id_busB), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_aluctr(id_aluctr), .id_ctrl(id_ctrl),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_pc_plus4(s_pc_plus4), .ex_inst(s_inst),
    .ex_imm(s_imm), .ex_busA(s_busA), .ex_busB(s_busB), .ex_rs(s_rs), .ex_rt(s_rt),
    .ex_rd(s_rd), .ex_shamt(s_shamt), .ex_aluctr(s_aluctr), .ex_ctrl(s_ctrl),
    .bubble_cnt(s_bcnt), .flush_cnt(s_fcnt));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic fl, st, cl, v;
    logic [31:0] pc;
    logic [23:0] ctrl;
    logic [4:0]  rt;
    logic        e_v;
    logic [31:0] e_pc;
    logic [23:0] e_ctrl;
    logic [4:0]  e_rt;
    logic [31:0] e_busA;
    logic [4:0]  e_alu;
    logic [15:0] e_b, e_f;
  } vec_t;

  vec_t vt[12];

  initial begin
    //            fl st cl v  pc        ctrl         rt   | v pc        ctrl         rt   busA           alu    b  f
    vt[0]  = '{0,0,0,1, 32'h100, 24'h0005A5, 5'd3,   1, 32'h100, 24'h0005A5, 5'd3, ~32'h100, 5'h11, 16'd0, 16'd0};
    vt[1]  = '{0,0,1,1, 32'h104, 24'hFFFFFF, 5'd7,   0, 32'h0,   24'h0,      5'd0, 32'h0,    5'h0,  16'd1, 16'd0};
    vt[2]  = '{0,0,0,1, 32'h104, 24'hFFFFFF, 5'd7,   1, 32'h104, 24'hFFFFFF, 5'd7, ~32'h104, 5'h11, 16'd1, 16'd0};
    vt[3]  = '{0,0,0,1, 32'h200, 24'h000123, 5'd9,   1, 32'h200, 24'h000123, 5'd9, ~32'h200, 5'h11, 16'd1, 16'd0};
    vt[4]  = '{0,1,1,1, 32'h204, 24'h000456, 5'd4,   1, 32'h200, 24'h000123, 5'd9, ~32'h200, 5'h11, 16'd1, 16'd0};
    vt[5]  = vt[4];
    vt[6]  = vt[4];
    vt[7]  = '{1,1,0,1, 32'h208, 24'h000777, 5'd6,   0, 32'h0,   24'h0,      5'd0, 32'h0,    5'h0,  16'd1, 16'd1};
    vt[8]  = '{0,0,0,0, 32'h300, 24'h000FFF, 5'd5,   0, 32'h300, 24'h0,      5'd5, ~32'h300, 5'h11, 16'd1, 16'd1};
    vt[9]  = '{1,0,0,0, 32'h304, 24'h000FFF, 5'd5,   0, 32'h0,   24'h0,      5'd0, 32'h0,    5'h0,  16'd1, 16'd1};
    vt[10] = '{1,0,1,1, 32'h308, 24'h000FFF, 5'd5,   0, 32'h0,   24'h0,      5'd0, 32'h0,    5'h0,  16'd1, 16'd2};
    vt[11] = '{0,0,0,1, 32'h40C, 24'h000ABC, 5'd1,   1, 32'h40C, 24'h000ABC, 5'd1, ~32'h40C, 5'h11, 16'd1, 16'd2};

    // Reset state, then a mid-cycle async reset during a load.
    step(); step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    rst = 1'b0;
    idex_clear = 1; id_valid = 1; id_pc = 32'h40; id_rt = 5'd2; id_ctrl = 24'h3;
    step();
    chk("pre_bcnt", bubble_cnt, 1);
    idex_clear = 0;
    step();
    chk("ld40_pc", ex_pc, 32'h40);
    chk("ld40_valid", ex_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_pc", ex_pc, 0);
    chk("arst_ctrl", ex_ctrl, 0);
    chk("arst_rt", ex_rt, 0);
    chk("arst_bcnt", bubble_cnt, 0);
    #1 rst = 1'b0;
    step();
    chk("rel_pc", ex_pc, 32'h40);
    chk("rel_valid", ex_valid, 1);
    chk("rel_ctrl", ex_ctrl, 24'h3);

    for (int i = 0; i < 12; i++) begin
      flush = vt[i].fl; ex_stall = vt[i].st; idex_clear = vt[i].cl; id_valid = vt[i].v;
      id_pc = vt[i].pc; id_ctrl = vt[i].ctrl; id_rt = vt[i].rt;
      step();
      chk($sformatf("v%0d_valid", i), ex_valid, vt[i].e_v);
      chk($sformatf("v%0d_pc", i), ex_pc, vt[i].e_pc);
      chk($sformatf("v%0d_ctrl", i), ex_ctrl, vt[i].e_ctrl);
      chk($sformatf("v%0d_rt", i), ex_rt, vt[i].e_rt);
      chk($sformatf("v%0d_busA", i), ex_busA, vt[i].e_busA);
      chk($sformatf("v%0d_aluctr", i), ex_aluctr, vt[i].e_alu);
      chk($sformatf("v%0d_bcnt", i), bubble_cnt, vt[i].e_b);
      chk($sformatf("v%0d_fcnt", i), flush_cnt, vt[i].e_f);
    end

    // Saturation: 20 consecutive clears on a 4-bit counter stop at 15.
    flush = 0; ex_stall = 0; idex_clear = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    idex_clear = 1;
    for (int i = 0; i < 14; i++) step();
    chk("sat_b14", s_bcnt, 14);
    for (int i = 0; i < 6; i++) step();
    chk("sat_b20", s_bcnt, 15);
    chk("wide_b20", bubble_cnt, 20);
    chk("sat_valid", s_valid, 0);
    idex_clear = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
